// File: rtl/axi4_lite_if.sv
// axi4_lite_if: AXI4-Lite bus bundle with 32-bit data and master/slave views.
interface axi4_lite_if #(
  parameter int ADDR_WIDTH = 32
) (
  input logic ACLK,
  input logic ARESETn
);
  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [31:0]           WDATA;
  logic [3:0]            WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [31:0]           RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;
  modport master (
    input  ACLK, ARESETn,
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, output RREADY
  );
  modport slave (
    input  ACLK, ARESETn,
    input  AWADDR, AWPROT, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite master driven by a cmd/rsp handshake.
// Optional response watchdog enabled by defining AXIL_MASTER_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_WIDTH     = 32
) (
  axi4_lite_if.master            m_axi,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [31:0]            cmd_wdata,
  input  logic [3:0]             cmd_wstrb,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [31:0]            rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic                   rsp_timeout
);
  typedef enum logic [2:0] {IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;
  typedef struct packed {
    logic                  awv, wv, arv, br, rr, cr, rv, rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wd, rd;
    logic [3:0]            ws;
    logic [1:0]            rs;
  } regs_t;
  if (TIMEOUT_CYCLES < 1) $error("TIMEOUT_CYCLES must be at least 1");
  state_t s, s_n;
  regs_t  q, n;
  logic   wr;
  assign wr = (s == WR_ADDR_DATA) || (s == WR_RESP);
`ifdef AXIL_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt, cnt_n;
  logic          to, to_n, busy, tmo;
  assign busy = (s != IDLE) && (s != RSP);
  assign tmo  = busy && (cnt == CW'(TIMEOUT_CYCLES - 1));
`endif
  always_comb begin
    s_n = s;
    n   = q;
    case (s)
      IDLE: if (cmd_valid && q.cr) begin
        s_n    = cmd_write ? WR_ADDR_DATA : RD_ADDR;
        n.awv  = cmd_write;
        n.wv   = cmd_write;
        n.br   = cmd_write;
        n.arv  = !cmd_write;
        n.addr = cmd_addr & ~ADDR_WIDTH'(3);
        n.wd   = cmd_wdata;
        n.ws   = cmd_wstrb;
      end
      WR_ADDR_DATA: begin
        if (m_axi.AWREADY) n.awv = 1'b0;
        if (m_axi.WREADY) n.wv = 1'b0;
        if (!n.awv && !n.wv) s_n = m_axi.BVALID ? RSP : WR_RESP;
      end
      WR_RESP: if (m_axi.BVALID) s_n = RSP;
      RD_ADDR: if (m_axi.ARREADY) begin
        n.arv = 1'b0;
        n.rr  = 1'b1;
        s_n   = RD_DATA;
      end
      RD_DATA: if (m_axi.RVALID) s_n = RSP;
      RSP: if (rsp_ready) begin
        n.rv = 1'b0;
        s_n  = IDLE;
      end
      default: s_n = IDLE;
    endcase
    if (s != RSP && s_n == RSP) begin
      n.br = 1'b0;
      n.rr = 1'b0;
      n.rv = 1'b1;
      n.rw = wr;
      n.rd = wr ? 32'h0 : m_axi.RDATA;
      n.rs = wr ? m_axi.BRESP : m_axi.RRESP;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
    // Watchdog deliberately abandons the handshake so a dead slave cannot hang us.
    if (tmo) begin
      s_n   = RSP;
      n.awv = 1'b0;
      n.wv  = 1'b0;
      n.arv = 1'b0;
      n.br  = 1'b0;
      n.rr  = 1'b0;
      n.rv  = 1'b1;
      n.rw  = wr;
      n.rd  = 32'h0;
      n.rs  = 2'b10;
    end
    to_n  = tmo ? 1'b1 : (s == IDLE && cmd_valid && q.cr) ? 1'b0 : to;
    cnt_n = (busy && !tmo) ? cnt + 1'b1 : '0;
`endif
    n.cr = (s_n == IDLE);
  end
  always_ff @(posedge m_axi.ACLK or negedge m_axi.ARESETn)
    if (!m_axi.ARESETn) begin
      s <= IDLE;
      q <= '0;
    end else begin
      s <= s_n;
      q <= n;
    end
`ifdef AXIL_MASTER_TIMEOUT_EN
  always_ff @(posedge m_axi.ACLK or negedge m_axi.ARESETn)
    if (!m_axi.ARESETn) begin
      cnt <= '0;
      to  <= 1'b0;
    end else begin
      cnt <= cnt_n;
      to  <= to_n;
    end
  assign rsp_timeout = to;
`else
  assign rsp_timeout = 1'b0;
`endif
  assign m_axi.AWADDR  = q.addr;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWVALID = q.awv;
  assign m_axi.WDATA   = q.wd;
  assign m_axi.WSTRB   = q.ws;
  assign m_axi.WVALID  = q.wv;
  assign m_axi.BREADY  = q.br;
  assign m_axi.ARADDR  = q.addr;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARVALID = q.arv;
  assign m_axi.RREADY  = q.rr;
  assign cmd_ready     = q.cr;
  assign rsp_valid     = q.rv;
  assign rsp_write     = q.rw;
  assign rsp_rdata     = q.rd;
  assign rsp_resp      = q.rs;
endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed AXI4-Lite master bench with a response scoreboard.
module tb_axi4_lite_master;
  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
    logic        t;
  } rsp_t;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  int          vecs = 0;
  int          errs = 0;
  int          aw_cnt = 0;
  int          w_cnt = 0;
  rsp_t        exq[$];
  rsp_t        e;
  axi4_lite_if #(.ADDR_WIDTH(32)) bus (.ACLK(clk), .ARESETn(rst_n));
  axi4_lite_master #(.TIMEOUT_CYCLES(16), .ADDR_WIDTH(32)) dut (
    .m_axi(bus), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout)
  );
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      cyc();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    cmd_wstrb = s;
    cmd_valid = 1'b1;
    cyc();
    cmd_valid = 1'b0;
  endtask
  always @(posedge clk) begin
    if (bus.AWVALID && bus.AWREADY) aw_cnt++;
    if (bus.WVALID && bus.WREADY) w_cnt++;
  end
  always @(negedge clk)
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exq.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL rsp_unexpected: response write=%b resp=%b with empty queue", rsp_write, rsp_resp);
      end else begin
        e = exq.pop_front();
        chk("rsp_write", rsp_write, e.w);
        chk("rsp_rdata", rsp_rdata, e.d);
        chk("rsp_resp", rsp_resp, e.r);
        chk("rsp_timeout", rsp_timeout, e.t);
      end
    end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int aw0, w0, bad, n;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0; rsp_ready = 1;
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0; bus.BRESP = 0;
    bus.ARREADY = 0; bus.RVALID = 0; bus.RDATA = 0; bus.RRESP = 0;
    repeat (3) cyc();
    chk("rst_awvalid", bus.AWVALID, 0);
    chk("rst_wvalid", bus.WVALID, 0);
    chk("rst_arvalid", bus.ARVALID, 0);
    chk("rst_bready", bus.BREADY, 0);
    chk("rst_rready", bus.RREADY, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_awaddr", bus.AWADDR, 0);
    rst_n = 1'b1;
    cyc();
    chk("cmd_ready_after_rst", cmd_ready, 1);
    // write, AWREADY one cycle ahead of WREADY
    aw0 = aw_cnt; w0 = w_cnt;
    exq.push_back('{w: 1'b1, d: 32'h0, r: 2'b00, t: 1'b0});
    send(1, 32'h04, 32'hDEADBEEF, 4'hF);
    chk("wr_awvalid", bus.AWVALID, 1);
    chk("wr_wvalid", bus.WVALID, 1);
    chk("wr_awaddr", bus.AWADDR, 32'h04);
    chk("wr_wdata", bus.WDATA, 32'hDEADBEEF);
    chk("wr_wstrb", bus.WSTRB, 4'hF);
    chk("wr_bready", bus.BREADY, 1);
    chk("wr_cmd_ready_busy", cmd_ready, 0);
    bus.AWREADY = 1;
    cyc();
    bus.AWREADY = 0;
    chk("wr_aw_dropped", bus.AWVALID, 0);
    chk("wr_w_held", bus.WVALID, 1);
    bus.WREADY = 1;
    cyc();
    bus.WREADY = 0;
    chk("wr_w_dropped", bus.WVALID, 0);
    chk("wr_resp_bready", bus.BREADY, 1);
    chk("wr_no_rsp_yet", rsp_valid, 0);
    bus.BVALID = 1;
    bus.BRESP = 2'b00;
    cyc();
    bus.BVALID = 0;
    chk("wr_rsp_valid", rsp_valid, 1);
    chk("wr_bready_dropped", bus.BREADY, 0);
    chk("wr_aw_beats", aw_cnt - aw0, 1);
    chk("wr_w_beats", w_cnt - w0, 1);
    cyc();
    // read with unaligned address and 3 wait cycles on R
    exq.push_back('{w: 1'b0, d: 32'h12345678, r: 2'b00, t: 1'b0});
    send(0, 32'h07, 32'h0, 4'h0);
    chk("rd_arvalid", bus.ARVALID, 1);
    chk("rd_araddr", bus.ARADDR, 32'h04);
    chk("rd_no_awvalid", bus.AWVALID, 0);
    bus.ARREADY = 1;
    cyc();
    bus.ARREADY = 0;
    chk("rd_ar_dropped", bus.ARVALID, 0);
    chk("rd_rready", bus.RREADY, 1);
    repeat (3) cyc();
    chk("rd_wait_no_rsp", rsp_valid, 0);
    bus.RVALID = 1;
    bus.RDATA = 32'h12345678;
    bus.RRESP = 2'b00;
    cyc();
    bus.RVALID = 0;
    chk("rd_rsp_valid", rsp_valid, 1);
    chk("rd_rready_dropped", bus.RREADY, 0);
    cyc();
    // all slave readies in the first cycle, response back-pressured for 5 cycles
    rsp_ready = 0;
    aw0 = aw_cnt; w0 = w_cnt;
    send(1, 32'h10, 32'hA5A50F0F, 4'h3);
    bus.AWREADY = 1; bus.WREADY = 1; bus.BVALID = 1; bus.BRESP = 2'b01;
    cyc();
    bus.AWREADY = 0; bus.WREADY = 0; bus.BVALID = 0;
    chk("fast_rsp_valid", rsp_valid, 1);
    bad = 0;
    repeat (5) begin
      if (!(rsp_valid && rsp_write && rsp_resp == 2'b01 && rsp_rdata == 0 && !cmd_ready)) bad++;
      cyc();
    end
    chk("fast_rsp_hold", bad, 0);
    chk("fast_aw_beats", aw_cnt - aw0, 1);
    chk("fast_w_beats", w_cnt - w0, 1);
    exq.push_back('{w: 1'b1, d: 32'h0, r: 2'b01, t: 1'b0});
    rsp_ready = 1;
    cyc();
    chk("fast_idle_cmd_ready", cmd_ready, 1);
    chk("fast_rsp_cleared", rsp_valid, 0);
    // SLVERR passes through unchanged, AW and W together
    exq.push_back('{w: 1'b1, d: 32'h0, r: 2'b10, t: 1'b0});
    send(1, 32'h20, 32'h0BADF00D, 4'h1);
    bus.AWREADY = 1; bus.WREADY = 1;
    cyc();
    bus.AWREADY = 0; bus.WREADY = 0;
    chk("slverr_wr_resp_state", bus.BREADY, 1);
    bus.BVALID = 1; bus.BRESP = 2'b10;
    cyc();
    bus.BVALID = 0;
    cyc();
    // reset mid-read abandons the transaction
    send(0, 32'h30, 32'h0, 4'h0);
    chk("rst_mid_arvalid", bus.ARVALID, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_ar_dropped", bus.ARVALID, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("rst_release_cmd_ready", cmd_ready, 1);
    bad = 0;
    repeat (3) begin
      if (rsp_valid || bus.ARVALID) bad++;
      cyc();
    end
    chk("rst_no_rsp", bad, 0);
    exq.push_back('{w: 1'b0, d: 32'hCAFEF00D, r: 2'b11, t: 1'b0});
    send(0, 32'h08, 32'h0, 4'h0);
    chk("post_rst_araddr", bus.ARADDR, 32'h08);
    bus.ARREADY = 1;
    cyc();
    bus.ARREADY = 0;
    bus.RVALID = 1; bus.RDATA = 32'hCAFEF00D; bus.RRESP = 2'b11;
    cyc();
    bus.RVALID = 0;
    chk("post_rst_rsp_valid", rsp_valid, 1);
    cyc();
`ifdef AXIL_MASTER_TIMEOUT_EN
    // dead slave: ARREADY never rises
    exq.push_back('{w: 1'b0, d: 32'h0, r: 2'b10, t: 1'b1});
    send(0, 32'h40, 32'h0, 4'h0);
    n = 0;
    while (bus.ARVALID && n < 40) begin
      n++;
      cyc();
    end
    chk("tmo_arvalid_cycles", n, 16);
    chk("tmo_rsp_valid", rsp_valid, 1);
    cyc();
`endif
    n = 0;
    while (exq.size() != 0 && n < 20) begin
      n++;
      cyc();
    end
    chk("queue_drain", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/axi4_lite_master.md
AXI4_LITE_MASTER -- requirements
Module: axi4_lite_master

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 256, response wait limit in ACLK cycles (used only with AXIL_MASTER_TIMEOUT_EN).
REQ-002 SHALL have port: m_axi.ACLK  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port: m_axi.ARESETn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: m_axi  axi4_lite_if.master  -  AXI4-Lite master bus; ADDR_WIDTH taken from the interface; data is 32 bits.
REQ-005 SHALL have port: cmd_valid  input  1  command offered.
REQ-006 SHALL have port: cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-007 SHALL have port: cmd_write  input  1  1 = write, 0 = read.
REQ-008 SHALL have port: cmd_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have port: cmd_wdata  input  32  write data.
REQ-010 SHALL have port: cmd_wstrb  input  4  write byte strobes.
REQ-011 SHALL have port: rsp_valid  output  1  response available.
REQ-012 SHALL have port: rsp_ready  input  1  response consumed when high with rsp_valid.
REQ-013 SHALL have port: rsp_write  output  1  response belongs to a write.
REQ-014 SHALL have port: rsp_rdata  output  32  read data (0 for writes).
REQ-015 SHALL have port: rsp_resp  output  2  captured BRESP/RRESP.
REQ-016 SHALL have port: rsp_timeout  output  1  transaction aborted by watchdog.

Function
REQ-017 SHALL implement states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP; one transaction outstanding at a time.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; a cmd handshake latches cmd_* and moves to WR_ADDR_DATA (write) or RD_ADDR (read).
REQ-019 SHALL assert AWVALID and WVALID together in the cycle after cmd handshake; each drops on its own handshake; both done -> WR_RESP, including both in the same cycle.
REQ-020 SHALL drive AWADDR/ARADDR = latched address with bits [1:0] forced to 0; WDATA/WSTRB = latched values; all held stable while the corresponding VALID is high.
REQ-021 SHALL assert BREADY in WR_ADDR_DATA and WR_RESP; B handshake captures BRESP -> RSP.
REQ-022 SHALL assert ARVALID in the cycle after cmd handshake until ARREADY; then RD_DATA with RREADY=1; R handshake captures RDATA/RRESP -> RSP.
REQ-023 SHALL drive rsp_valid=1 in RSP the cycle after the B/R handshake, outputs held stable until rsp_ready; rsp_ready handshake -> IDLE, cmd_ready high the next cycle.
REQ-024 SHALL never assert any AXI VALID signal combinationally from an AXI READY input; all AXI outputs registered.
REQ-025 SHALL pass RESP codes through unchanged (SLVERR/DECERR are not retried).

Reset
REQ-026 SHALL clear all state asynchronously on ARESETn low: state=IDLE, AWVALID=WVALID=ARVALID=0, BREADY=RREADY=0, cmd_ready=0, rsp_valid=0, rsp_* =0, addresses/data=0.
REQ-027 SHALL abandon any transaction in flight on reset with no response generated; cmd_ready rises on the first clock edge after ARESETn deasserts.

Configuration
REQ-028 SHALL, with AXIL_MASTER_TIMEOUT_EN defined, count cycles spent in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_DATA. At TIMEOUT_CYCLES it SHALL drop all AXI VALID/READY, enter RSP with rsp_resp=2'b10, rsp_timeout=1, rsp_rdata=0. The counter restarts per transaction. This deliberately violates AXI stability to allow recovery from a dead slave.
REQ-029 SHALL, without AXIL_MASTER_TIMEOUT_EN, wait indefinitely, tie rsp_timeout=0, and contain no counter logic.

Verification
REQ-030 Write cmd addr=0x04 wdata=0xDEADBEEF wstrb=0xF; slave AWREADY one cycle before WREADY, BRESP=00 -> one AW and one W beat, AWADDR=0x04, then rsp_valid, rsp_write=1, rsp_resp=00.
REQ-031 Read cmd addr=0x07; slave returns RDATA=0x12345678 RRESP=00 after 3 wait cycles -> ARADDR=0x04, rsp_rdata=0x12345678, rsp_write=0.
REQ-032 AWREADY, WREADY and BVALID all high on the first cycle; rsp_ready held low 5 cycles -> rsp_* stable, cmd_ready=0 throughout, IDLE one cycle after rsp_ready.
REQ-033 Slave returns BRESP=2'b10 -> rsp_resp=2'b10, rsp_timeout=0.
REQ-034 ARESETn pulled low while ARVALID=1 -> ARVALID=0 immediately, no rsp_valid after release, next command completes normally.
REQ-035 With AXIL_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, slave never asserts ARREADY -> ARVALID drops after 16 cycles, rsp_timeout=1, rsp_resp=2'b10.
